// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: FSM state encodings, error codes and frame constants.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAGIC = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } ld_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_MAGIC   = 2'd1,
        ERR_CHKSUM  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

    // A length byte of zero encodes a full 256-byte image.
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'h00) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
interface prog_loader_if #(
    parameter int PM_ADDR_W = 8
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 pm_we;
    logic [PM_ADDR_W-1:0] pm_addr;
    logic [7:0]           pm_wdata;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output pm_we,
        output pm_addr,
        output pm_wdata
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  pm_we,
        input  pm_addr,
        input  pm_wdata
    );
endinterface

// File: rtl/prog_loader_timeout.sv
// Inter-byte watchdog: down-counter reloaded on clr, expired when it reaches zero.
module loader_timeout #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic i_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Reload of TIMEOUT-2 lets the FSM land in ERR exactly TIMEOUT cycles after the last handshake.
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = RELOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);
endmodule

// File: rtl/prog_loader.sv
// Loads a framed program image (magic, length, payload, checksum) into program memory
// while holding the CPU in reset; releases it only after a clean load.
//
// state | meaning
// IDLE  | waiting for start, stream not accepted
// MAGIC | expecting the magic byte
// LEN   | expecting the payload length (0 = 256)
// DATA  | writing payload bytes to program memory
// CHK   | expecting the checksum byte
// DONE  | one-cycle success pulse
// ERR   | one-cycle error state, err latched
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         PM_ADDR_W = 8,
    parameter int         TIMEOUT   = 1000000,
    parameter logic [7:0] MAGIC     = DEFAULT_MAGIC
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code
);
    ld_state_e            state_q, state_d;
    logic [PM_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]           sum_q, sum_d;
    logic [8:0]           rem_q, rem_d;
    logic                 pm_we_q, pm_we_d;
    logic [PM_ADDR_W-1:0] pm_addr_q, pm_addr_d;
    logic [7:0]           pm_wdata_q, pm_wdata_d;
    logic                 err_q, err_d;
    err_code_e            err_code_q, err_code_d;

    logic       active;
    logic       hs;
    logic       tmo_clr;
    logic       tmo_expired;
    logic [7:0] chk_total;

    assign active    = (state_q == ST_MAGIC) || (state_q == ST_LEN) ||
                       (state_q == ST_DATA)  || (state_q == ST_CHK);
    assign hs        = active && bus.rx_valid;
    assign chk_total = sum_q + bus.rx_data;
    assign tmo_clr   = !active || hs || (state_d != state_q);

    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .i_rst   (i_rst),
        .clr     (tmo_clr),
        .en      (active),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sum_d      = sum_q;
        rem_d      = rem_q;
        pm_we_d    = 1'b0;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_MAGIC;
                end
            end
            ST_MAGIC: begin
                if (hs) begin
                    if (bus.rx_data == MAGIC) begin
                        state_d = ST_LEN;
                    end else begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_MAGIC;
                    end
                end
            end
            ST_LEN: begin
                if (hs) begin
                    rem_d   = frame_len(bus.rx_data);
                    addr_d  = '0;
                    sum_d   = 8'h00;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hs) begin
                    pm_we_d    = 1'b1;
                    pm_addr_d  = addr_q;
                    pm_wdata_d = bus.rx_data;
                    addr_d     = addr_q + PM_ADDR_W'(1);
                    sum_d      = sum_q + bus.rx_data;
                    rem_d      = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (hs) begin
                    if (chk_total == 8'h00) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_CHKSUM;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // An accepted byte in the same cycle always beats the watchdog.
        if (active && !hs && tmo_expired) begin
            state_d    = ST_ERR;
            err_code_d = ERR_TIMEOUT;
        end

        if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            sum_q      <= 8'h00;
            rem_q      <= 9'd0;
            pm_we_q    <= 1'b0;
            pm_addr_q  <= '0;
            pm_wdata_q <= 8'h00;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sum_q      <= sum_d;
            rem_q      <= rem_d;
            pm_we_q    <= pm_we_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.rx_ready = active;
    assign bus.pm_we    = pm_we_q;
    assign bus.pm_addr  = pm_addr_q;
    assign bus.pm_wdata = pm_wdata_q;
    assign busy         = (state_q != ST_IDLE);
    assign cpu_rst      = busy || err_q;
    assign done         = (state_q == ST_DONE);
    assign err          = err_q;
    assign err_code     = err_code_q;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected writes/outcomes, a monitor checks them.
module tb_prog_loader;
    localparam int AW  = 8;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       start;
    logic       cpu_rst, busy, done, err;
    logic [1:0] err_code;

    prog_loader_if #(.PM_ADDR_W(AW)) bus ();

    prog_loader #(.PM_ADDR_W(AW), .TIMEOUT(TMO), .MAGIC(8'hA5)) dut (
        .clk      (clk),
        .i_rst    (i_rst),
        .start    (start),
        .bus      (bus),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int code; int cyc; } res_t;
    wr_t  wq[$];
    res_t rq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        if (i_rst === 1'b0) begin
            if (bus.pm_we === 1'b1) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h expected none", bus.pm_addr, bus.pm_wdata);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", 32'(bus.pm_addr), w.addr);
                    chk("wr_data", 32'(bus.pm_wdata), w.data);
                    chk("wr_cycle", cyc, w.cyc);
                end
            end
            if (done === 1'b1 || (err === 1'b1 && busy === 1'b1)) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_outcome: done %0b err_code %0d expected none", done, err_code);
                end else begin
                    r = rq.pop_front();
                    chk("outcome_code", {30'd0, err_code}, r.code);
                    chk("outcome_done", {31'd0, done}, (r.code == 0) ? 1 : 0);
                    chk("outcome_cycle", cyc, r.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, output int hs);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("rx_ready", {31'd0, bus.rx_ready}, 1);
        hs = cyc;
        tick();
    endtask

    task automatic send_data(input logic [7:0] b, input int addr);
        int hs;
        send(b, hs);
        wq.push_back('{addr: addr, data: int'(b), cyc: hs + 1});
    endtask

    task automatic push_res(input int code, input int at);
        rq.push_back('{code: code, cyc: at});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic idle();
        bus.rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() + rq.size()) != 0 && n < 400) begin
            tick();
            n++;
        end
        chk("drain", wq.size() + rq.size(), 0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {8'd0, bus.rx_ready, bus.pm_we, bus.pm_addr, bus.pm_wdata,
                   cpu_rst, busy, done, err, err_code}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, hs2;
        i_rst        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #12;
        chk_reset_vals("reset_values");
        i_rst = 1'b0;
        tick();

        // Good 3-byte frame
        pulse_start();
        chk("t1_busy_after_start", {31'd0, busy}, 1);
        chk("t1_cpu_rst_after_start", {31'd0, cpu_rst}, 1);
        send(8'hA5, hs);
        send(8'h03, hs);
        send_data(8'h11, 0);
        send_data(8'h22, 1);
        send_data(8'h33, 2);
        send(8'h9A, hs);
        push_res(0, hs + 1);
        idle();
        drain();
        chk("t1_cpu_rst_released", {31'd0, cpu_rst}, 0);
        chk("t1_err", {31'd0, err}, 0);

        // Bad magic
        pulse_start();
        send(8'h5A, hs);
        push_res(1, hs + 1);
        idle();
        drain();
        repeat (3) tick();
        chk("t2_err", {31'd0, err}, 1);
        chk("t2_err_code", {30'd0, err_code}, 1);
        chk("t2_cpu_rst_held", {31'd0, cpu_rst}, 1);
        chk("t2_busy", {31'd0, busy}, 0);

        // Bad checksum
        pulse_start();
        chk("t3_err_cleared", {31'd0, err}, 0);
        send(8'hA5, hs);
        send(8'h02, hs);
        send_data(8'h10, 0);
        send_data(8'h20, 1);
        send(8'h00, hs);
        push_res(2, hs + 1);
        idle();
        drain();
        chk("t3_err_code", {30'd0, err_code}, 2);
        chk("t3_cpu_rst_held", {31'd0, cpu_rst}, 1);

        // Timeout: handshake on idle cycle 15 survives, then a full timeout in DATA
        pulse_start();
        chk("t4_err_cleared", {29'd0, err, err_code}, 0);
        send(8'hA5, hs);
        idle();
        repeat (14) tick();
        send(8'h02, hs2);
        chk("t4_late_handshake_cycle", hs2 - hs, 15);
        idle();
        push_res(3, hs2 + 16);
        drain();
        chk("t4_err_code", {30'd0, err_code}, 3);
        chk("t4_cpu_rst_held", {31'd0, cpu_rst}, 1);

        // Full 256-byte image, address wraps
        pulse_start();
        send(8'hA5, hs);
        send(8'h00, hs);
        for (int i = 0; i < 256; i++) send_data(8'h01, i);
        send(8'h00, hs);
        push_res(0, hs + 1);
        idle();
        drain();
        chk("t5_cpu_rst_released", {31'd0, cpu_rst}, 0);
        chk("t5_last_addr", 32'(bus.pm_addr), 255);

        // start while busy is ignored; async reset mid-DATA
        pulse_start();
        send(8'hA5, hs);
        send(8'h04, hs);
        send_data(8'hAA, 0);
        send_data(8'hBB, 1);
        idle();
        tick();
        pulse_start();
        chk("t6_busy_ignored_start", {31'd0, busy}, 1);
        send_data(8'hCC, 2);
        idle();
        tick();
        chk("t6_queue_empty", wq.size(), 0);
        #2;
        i_rst = 1'b1;
        #1;
        chk_reset_vals("t6_async_reset");
        #3;
        i_rst = 1'b0;
        tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        #1;
        chk("t6_idle_rx_ready", {31'd0, bus.rx_ready}, 0);
        tick();
        chk("t6_idle_not_busy", {31'd0, busy}, 0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Sequencer that loads a new program image into HRM CPU program memory from a byte stream (UART RX side) while holding the CPU in reset, then releases it. It sits between the UART receiver and the program-memory write port, and drives the CPU core reset. The image is framed as magic byte, length byte, payload and checksum. Framing, checksum and inter-byte timeout errors keep the CPU parked in reset until the next load request.

## Interface
- PM_ADDR_W, 8, program memory address width (max image 256 bytes)
- TIMEOUT, 1000000, max idle cycles between accepted bytes during a load (>=2)
- MAGIC, 8'hA5, required first byte of a frame
- clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- start  in  1  load request pulse; honoured only in IDLE
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte this cycle
- pm_we  out  1  program memory write strobe (registered)
- pm_addr  out  PM_ADDR_W  write address (registered)
- pm_wdata  out  8  write data (registered)
- cpu_rst  out  1  hold CPU core in reset
- busy  out  1  load in progress (state not IDLE)
- done  out  1  one-cycle pulse, load completed OK
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 bad magic, 2 bad checksum, 3 timeout

## Operation
- States: IDLE, MAGIC, LEN, DATA, CHK, DONE, ERR.
- IDLE: rx_ready=0. On start, clear err/err_code, go to MAGIC.
- MAGIC: on handshake (rx_valid&rx_ready), byte==MAGIC goes to LEN; otherwise go to ERR with code 1.
- LEN: on handshake latch N=byte. N=0 means 256 bytes. Clear addr counter and sum, go to DATA.
- DATA: each handshake issues write of byte to addr, then addr+1 and sum+=byte (mod 256). After the Nth byte go to CHK.
- CHK: on handshake, (sum+byte) mod 256 == 0 goes to DONE; else ERR with code 2.
- Timeout: a cycle counter clears on state entry and on every handshake, and counts otherwise in MAGIC..CHK. Reaching TIMEOUT goes to ERR with code 3. A timeout takes priority over nothing: a handshake in the same cycle wins.
- DONE: done=1 for one cycle, then IDLE.
- ERR: set err, then IDLE next cycle. err/err_code hold until the next accepted start.
- cpu_rst = (state != IDLE) || err. The CPU runs again only after a successful load.
- Payload bytes already written stay in memory on error. No rollback.
- start outside IDLE is ignored. rx bytes in IDLE are not accepted.

## Timing
- Reset values: state IDLE, rx_ready 0, pm_we 0, pm_addr 0, pm_wdata 0, cpu_rst 0, busy 0, done 0, err 0, err_code 0. Counters are 0.
- rx_ready=1 combinationally in MAGIC, LEN, DATA, CHK. Throughput is one byte per cycle.
- Write latency: pm_we/pm_addr/pm_wdata are valid the cycle after the DATA handshake, for exactly one cycle.
- The last payload write occurs in the first CHK cycle.
- start in IDLE gives busy and cpu_rst high on the next cycle.
- Successful frame with back-to-back bytes, start at cycle 0: N+3 handshakes in cycles 1..N+3, DONE at N+4, cpu_rst low at N+5.
- Addr counter is PM_ADDR_W bits. With N=256 it wraps to 0 after the last byte, which is harmless.
- i_rst mid-load: immediate return to reset values. A partial image remains in memory.

## Structure
- Shared header (hrm_defs): loader state encodings, err_code constants, default MAGIC.
- Sub-module `loader_timeout`: loadable/clearable down-counter with an `expired` output, parameterised by TIMEOUT. Everything else lives in prog_loader.

## Test plan
- start, then A5, 03, 11, 22, 33, 9A -> writes 11@0, 22@1, 33@2 on consecutive cycles; done pulse; cpu_rst falls; err=0.
- start, then 5A -> err=1, err_code=1, no pm_we, cpu_rst stays 1 until the next start.
- start, then A5, 02, 10, 20, 00 -> two writes, err_code=2, cpu_rst stays high; a new start clears err.
- TIMEOUT=16: start, A5, then rx_valid low for 16 cycles -> err_code=3 at cycle 16 after the last handshake. A handshake on cycle 15 prevents the timeout.
- start, A5, 00, 256 bytes of 01, chk 00 -> addresses 0..255 written, done, pm_addr wraps cleanly.
- i_rst asserted mid-DATA -> all outputs return to reset values asynchronously. start while busy has no effect.
